l2_port_arbiter: RTL and testbench
==================================

# l2_port_arbiter

Two-master, one-slave arbiter between the L1 instruction and data caches and the shared L2 cache. Accepts line-sized Avalon-style read and write requests from icache (read-only) and dcache (read/write). Forwards exactly one transaction at a time to the L2 port. Routes each L2 read response back to the master that issued it.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports.
- LINE_W, 128, cache-line data width of all data ports.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- i_ic_addr  in  ADDR_W  icache line address.
- i_ic_read  in  1  icache read request.
- o_ic_readdata  out  LINE_W  read line to icache.
- o_ic_readdata_valid  out  1  icache response strobe.
- o_ic_waitrequest  out  1  icache command stall.
- i_dc_addr  in  ADDR_W  dcache line address.
- i_dc_writedata  in  LINE_W  dcache write line.
- i_dc_read, i_dc_write  in  1 each  dcache commands.
- o_dc_readdata  out  LINE_W  read line to dcache.
- o_dc_readdata_valid  out  1  dcache response strobe.
- o_dc_waitrequest  out  1  dcache command stall.
- o_l2_addr  out  ADDR_W  L2 address.
- o_l2_byte_en  out  4  L2 byte enable; constant 4'b1111.
- o_l2_writedata  out  LINE_W  L2 write line.
- o_l2_read, o_l2_write  out  1 each  L2 command strobes.
- i_l2_readdata  in  LINE_W  L2 read line.
- i_l2_readdata_valid  in  1  L2 response strobe.
- i_l2_waitrequest  in  1  L2 command stall.

## Operation
- Masters use Avalon semantics: a command is held stable until the cycle its waitrequest is low; that cycle is acceptance.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Waitrequest is low only for the granted requesting master; the other master sees it high.
  - On acceptance, latch addr, writedata, op and owner; go to ISSUE.
  - With no request, waitrequest for both masters stays high and the FSM stays in IDLE.
- ISSUE:
  - Drive o_l2_read or o_l2_write from the latched op, with latched addr and data.
  - Hold while i_l2_waitrequest=1.
  - On accept, a write returns to IDLE and a read goes to RESP.
- RESP:
  - On i_l2_readdata_valid=1, assert the owner's readdata_valid combinationally in the same cycle, then return to IDLE.
- Both o_ic_readdata and o_dc_readdata are wired directly to i_l2_readdata.
- i_l2_readdata_valid outside RESP is ignored; it must not strobe either master.
- Both masters in both states ISSUE and RESP: waitrequest high.
- If i_dc_read and i_dc_write are high together, the write wins and the read is dropped.
- Default grant is fixed priority: dcache over icache. Icache starvation under continuous dcache traffic is accepted in this mode.

## Timing
- During rst and on the cycle after it:
  - State is IDLE.
  - o_l2_read=o_l2_write=0, o_l2_addr=0, o_l2_writedata=0.
  - Both readdata_valid outputs are 0.
  - Both waitrequest outputs are 1 during rst.
- Accept in cycle T puts the L2 strobe high in T+1.
- With a zero-wait L2, the fastest sequence is: write in 2 cycles, IDLE to IDLE; read in 3 cycles plus L2 read latency.
- Reset mid-transaction:
  - The in-flight op is dropped and strobes are low in the next cycle.
  - A late i_l2_readdata_valid is ignored.

## Configuration
- L2_ARB_RR_EN defined:
  - Round-robin grant using a last_grant register, updated on every acceptance and reset to icache. Effect: dcache wins the first contention after reset.
  - When both masters request in IDLE, the master not granted last time wins.
- Undefined: fixed dcache priority, and no last_grant register is present.

## Structure
- Package l2_arb_pkg holds:
  - State typedef: IDLE=2'd0, ISSUE=2'd1, RESP=2'd2.
  - Owner typedef: OWN_IC=1'b0, OWN_DC=1'b1.
  - Defaults ADDR_W=32 and LINE_W=128.
- One sub-module, l2_arb_grant: grant logic plus the optional last_grant register.

## Test plan
- dcache write addr 0x100, data 0xA5..A5, L2 waitrequest 0 -> o_l2_write=1 exactly one cycle with addr 0x100; dcache never gets readdata_valid.
- icache and dcache read simultaneously, addrs 0x40 and 0x80, fixed priority -> 0x80 issued first and the dcache response strobed; then 0x40 issued and routed to icache.
- Same stimulus with L2_ARB_RR_EN defined -> grant order alternates DC, IC, DC over three contended rounds.
- L2 waitrequest held 5 cycles during ISSUE -> o_l2_read and addr stay stable for 6 cycles, and both master waitrequests stay 1.
- Spurious i_l2_readdata_valid while in IDLE -> no master readdata_valid.
- rst asserted in RESP, then the response arrives -> it is ignored, and after reset a new icache read 0x200 completes normally.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// Shared types and default widths for the L2 port arbiter.
package l2_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned LINE_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

endpackage

// File: rtl/l2_arb_grant.sv
// Grant selection between icache and dcache.
// L2_ARB_RR_EN selects round-robin; otherwise dcache has fixed priority.
module l2_arb_grant
    import l2_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   ic_req,
    input  logic   dc_req,
    input  logic   accept,
    output owner_e grant
);

`ifdef L2_ARB_RR_EN
    owner_e last_grant_q;

    // Reset to icache so dcache wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= OWN_IC;
        end else if (accept) begin
            last_grant_q <= grant;
        end
    end

    always_comb begin
        grant = OWN_DC;
        if (ic_req && dc_req) begin
            grant = (last_grant_q == OWN_DC) ? OWN_IC : OWN_DC;
        end else if (ic_req) begin
            grant = OWN_IC;
        end
    end
`else
    logic unused_grant;
    assign unused_grant = ^{clk, rst, accept};

    always_comb begin
        grant = OWN_DC;
        if (ic_req && !dc_req) begin
            grant = OWN_IC;
        end
    end
`endif

endmodule

// File: rtl/l2_port_arbiter.sv
// Two-master (icache, dcache) to one-slave (L2) Avalon arbiter, one transaction in flight.
// Grant policy selected by L2_ARB_RR_EN (round-robin) or fixed dcache priority by default.
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_ic_addr,
    input  logic              i_ic_read,
    output logic [LINE_W-1:0] o_ic_readdata,
    output logic              o_ic_readdata_valid,
    output logic              o_ic_waitrequest,
    input  logic [ADDR_W-1:0] i_dc_addr,
    input  logic [LINE_W-1:0] i_dc_writedata,
    input  logic              i_dc_read,
    input  logic              i_dc_write,
    output logic [LINE_W-1:0] o_dc_readdata,
    output logic              o_dc_readdata_valid,
    output logic              o_dc_waitrequest,
    output logic [ADDR_W-1:0] o_l2_addr,
    output logic [3:0]        o_l2_byte_en,
    output logic [LINE_W-1:0] o_l2_writedata,
    output logic              o_l2_read,
    output logic              o_l2_write,
    input  logic [LINE_W-1:0] i_l2_readdata,
    input  logic              i_l2_readdata_valid,
    input  logic              i_l2_waitrequest
);

    state_e            state_q, state_d;
    owner_e            owner_q, grant;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] data_q;
    logic              op_write_q;
    logic              ic_req, dc_req, accept;

    assign ic_req = i_ic_read;
    assign dc_req = i_dc_read | i_dc_write;
    assign accept = (state_q == IDLE) && !rst && (ic_req || dc_req);

    l2_arb_grant u_grant (
        .clk    (clk),
        .rst    (rst),
        .ic_req (ic_req),
        .dc_req (dc_req),
        .accept (accept),
        .grant  (grant)
    );

    assign o_ic_readdata = i_l2_readdata;
    assign o_dc_readdata = i_l2_readdata;
    assign o_l2_byte_en  = 4'b1111;

    always_comb begin
        state_d             = state_q;
        o_ic_waitrequest    = 1'b1;
        o_dc_waitrequest    = 1'b1;
        o_l2_read           = 1'b0;
        o_l2_write          = 1'b0;
        o_l2_addr           = '0;
        o_l2_writedata      = '0;
        o_ic_readdata_valid = 1'b0;
        o_dc_readdata_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rst) begin
                    o_dc_waitrequest = !(dc_req && grant == OWN_DC);
                    o_ic_waitrequest = !(ic_req && grant == OWN_IC);
                end
                if (accept) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                o_l2_read      = !rst && !op_write_q;
                o_l2_write     = !rst && op_write_q;
                o_l2_addr      = rst ? '0 : addr_q;
                o_l2_writedata = rst ? '0 : data_q;
                if (!i_l2_waitrequest) begin
                    state_d = op_write_q ? IDLE : RESP;
                end
            end
            RESP: begin
                // Response strobe is forwarded in the same cycle it arrives.
                if (i_l2_readdata_valid && !rst) begin
                    o_dc_readdata_valid = (owner_q == OWN_DC);
                    o_ic_readdata_valid = (owner_q == OWN_IC);
                end
                if (i_l2_readdata_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IC;
            addr_q     <= '0;
            data_q     <= '0;
            op_write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q <= grant;
                if (grant == OWN_DC) begin
                    addr_q     <= i_dc_addr;
                    data_q     <= i_dc_writedata;
                    op_write_q <= i_dc_write;
                end else begin
                    addr_q     <= i_ic_addr;
                    data_q     <= '0;
                    op_write_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter; grant order expectations follow L2_ARB_RR_EN.
module tb_l2_port_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_ic_addr;
    logic         i_ic_read;
    logic [127:0] o_ic_readdata;
    logic         o_ic_readdata_valid;
    logic         o_ic_waitrequest;
    logic [31:0]  i_dc_addr;
    logic [127:0] i_dc_writedata;
    logic         i_dc_read;
    logic         i_dc_write;
    logic [127:0] o_dc_readdata;
    logic         o_dc_readdata_valid;
    logic         o_dc_waitrequest;
    logic [31:0]  o_l2_addr;
    logic [3:0]   o_l2_byte_en;
    logic [127:0] o_l2_writedata;
    logic         o_l2_read;
    logic         o_l2_write;
    logic [127:0] i_l2_readdata;
    logic         i_l2_readdata_valid;
    logic         i_l2_waitrequest;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    l2_port_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_ic_addr           (i_ic_addr),
        .i_ic_read           (i_ic_read),
        .o_ic_readdata       (o_ic_readdata),
        .o_ic_readdata_valid (o_ic_readdata_valid),
        .o_ic_waitrequest    (o_ic_waitrequest),
        .i_dc_addr           (i_dc_addr),
        .i_dc_writedata      (i_dc_writedata),
        .i_dc_read           (i_dc_read),
        .i_dc_write          (i_dc_write),
        .o_dc_readdata       (o_dc_readdata),
        .o_dc_readdata_valid (o_dc_readdata_valid),
        .o_dc_waitrequest    (o_dc_waitrequest),
        .o_l2_addr           (o_l2_addr),
        .o_l2_byte_en        (o_l2_byte_en),
        .o_l2_writedata      (o_l2_writedata),
        .o_l2_read           (o_l2_read),
        .o_l2_write          (o_l2_write),
        .i_l2_readdata       (i_l2_readdata),
        .i_l2_readdata_valid (i_l2_readdata_valid),
        .i_l2_waitrequest    (i_l2_waitrequest)
    );

    task automatic test_reset();
        rst = 1'b1;
        i_dc_read = 1'b1;
        i_dc_addr = 32'h10;
        @(negedge clk);
        checks++;
        if ({o_ic_waitrequest, o_dc_waitrequest} !== 2'b11) begin
            failures++;
            $display("FAIL reset_waitreq got %b exp 11", {o_ic_waitrequest, o_dc_waitrequest});
        end
        checks++;
        if ({o_l2_read, o_l2_write, o_ic_readdata_valid, o_dc_readdata_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes got %b exp 0000",
                     {o_l2_read, o_l2_write, o_ic_readdata_valid, o_dc_readdata_valid});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        i_dc_read = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_l2_read, o_l2_write} !== 2'b00 || o_l2_addr !== 32'h0 || o_l2_writedata !== 128'h0)
        begin
            failures++;
            $display("FAIL post_reset_l2 got rd=%b wr=%b addr=%h data=%h exp zeros",
                     o_l2_read, o_l2_write, o_l2_addr, o_l2_writedata);
        end
        checks++;
        if (o_l2_byte_en !== 4'hF) begin
            failures++;
            $display("FAIL byte_en got %h exp f", o_l2_byte_en);
        end
    endtask

    task automatic test_contention();
        logic [31:0] dc_addrs [3];
        logic [31:0] ic_addrs [3];
        logic [31:0] exp_order [6];
        logic [31:0] resp_addr = '0;
        int di = 0, ii = 0, n_issued = 0, n_resp = 0;
        logic dc_acc, ic_acc, l2_acc;
        dc_addrs = '{32'h80, 32'h90, 32'hA0};
        ic_addrs = '{32'h40, 32'h50, 32'h60};
`ifdef L2_ARB_RR_EN
        exp_order = '{32'h80, 32'h40, 32'h90, 32'h50, 32'hA0, 32'h60};
`else
        exp_order = '{32'h80, 32'h90, 32'hA0, 32'h40, 32'h50, 32'h60};
`endif
        @(posedge clk); #1;
        i_dc_read = 1'b1; i_dc_addr = dc_addrs[0];
        i_ic_read = 1'b1; i_ic_addr = ic_addrs[0];
        for (int cyc = 0; cyc < 60 && n_resp < 6; cyc++) begin
            @(negedge clk);
            dc_acc = i_dc_read && !o_dc_waitrequest;
            ic_acc = i_ic_read && !o_ic_waitrequest;
            l2_acc = o_l2_read && !i_l2_waitrequest;
            if (l2_acc) begin
                checks++;
                if (n_issued >= 6) begin
                    failures++;
                    $display("FAIL issue_count got %0d exp 6", n_issued + 1);
                end else if (o_l2_addr !== exp_order[n_issued]) begin
                    failures++;
                    $display("FAIL issue_order idx=%0d got %h exp %h",
                             n_issued, o_l2_addr, exp_order[n_issued]);
                end
                resp_addr = o_l2_addr;
                n_issued++;
            end
            if (i_l2_readdata_valid) begin
                checks++;
                if ({o_dc_readdata_valid, o_ic_readdata_valid} !==
                    (resp_addr[7] ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL route addr=%h got dc/ic=%b exp %b", resp_addr,
                             {o_dc_readdata_valid, o_ic_readdata_valid},
                             resp_addr[7] ? 2'b10 : 2'b01);
                end
                checks++;
                if ((resp_addr[7] ? o_dc_readdata : o_ic_readdata) !== {96'h0, ~resp_addr}) begin
                    failures++;
                    $display("FAIL route_data addr=%h got %h exp %h", resp_addr,
                             resp_addr[7] ? o_dc_readdata : o_ic_readdata, {96'h0, ~resp_addr});
                end
                n_resp++;
            end
            @(posedge clk); #1;
            i_l2_readdata_valid = 1'b0;
            if (l2_acc) begin
                i_l2_readdata_valid = 1'b1;
                i_l2_readdata = {96'h0, ~resp_addr};
            end
            if (dc_acc) begin
                di++;
                if (di < 3) i_dc_addr = dc_addrs[di];
                else i_dc_read = 1'b0;
            end
            if (ic_acc) begin
                ii++;
                if (ii < 3) i_ic_addr = ic_addrs[ii];
                else i_ic_read = 1'b0;
            end
        end
        i_dc_read = 1'b0; i_ic_read = 1'b0; i_l2_readdata_valid = 1'b0;
        checks++;
        if (n_resp != 6) begin
            failures++;
            $display("FAIL contention_done got %0d responses exp 6", n_resp);
        end
    endtask

    task automatic test_dc_write();
        int wr_cycles = 0;
        logic dc_valid_seen = 1'b0;
        @(posedge clk); #1;
        i_dc_write = 1'b1; i_dc_addr = 32'h100; i_dc_writedata = {16{8'hA5}};
        @(negedge clk);
        checks++;
        if (o_dc_waitrequest !== 1'b0) begin
            failures++;
            $display("FAIL wr_accept got waitreq=%b exp 0", o_dc_waitrequest);
        end
        @(posedge clk); #1;
        i_dc_write = 1'b0;
        @(negedge clk);
        checks++;
        if (o_l2_write !== 1'b1 || o_l2_read !== 1'b0 || o_l2_addr !== 32'h100 ||
            o_l2_writedata !== {16{8'hA5}}) begin
            failures++;
            $display("FAIL wr_issue got wr=%b rd=%b addr=%h data=%h exp 1 0 100 a5..a5",
                     o_l2_write, o_l2_read, o_l2_addr, o_l2_writedata);
        end
        for (int k = 0; k < 4; k++) begin
            if (o_l2_write === 1'b1) wr_cycles++;
            if (o_dc_readdata_valid !== 1'b0) dc_valid_seen = 1'b1;
            @(posedge clk); #1;
            i_l2_readdata_valid = (k == 1);
            @(negedge clk);
        end
        i_l2_readdata_valid = 1'b0;
        checks++;
        if (wr_cycles != 1 || dc_valid_seen !== 1'b0) begin
            failures++;
            $display("FAIL wr_once got cycles=%0d dc_valid=%b exp 1 0", wr_cycles, dc_valid_seen);
        end
    endtask

    task automatic test_rw_conflict();
        @(posedge clk); #1;
        i_dc_write = 1'b1; i_dc_read = 1'b1;
        i_dc_addr = 32'h500; i_dc_writedata = {16{8'h5A}};
        @(posedge clk); #1;
        i_dc_write = 1'b0; i_dc_read = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_l2_write, o_l2_read} !== 2'b10 || o_l2_addr !== 32'h500) begin
            failures++;
            $display("FAIL rw_conflict got wr/rd=%b addr=%h exp 10 500",
                     {o_l2_write, o_l2_read}, o_l2_addr);
        end
        @(posedge clk); #1;
        i_ic_read = 1'b1; i_ic_addr = 32'h600;
        @(negedge clk);
        checks++;
        if (o_ic_waitrequest !== 1'b0) begin
            failures++;
            $display("FAIL rw_back_idle got ic waitreq=%b exp 0", o_ic_waitrequest);
        end
        @(posedge clk); #1;
        i_ic_read = 1'b0;
        @(posedge clk); #1;
        i_l2_readdata_valid = 1'b1;
        @(posedge clk); #1;
        i_l2_readdata_valid = 1'b0;
    endtask

    task automatic test_l2_wait();
        int stable = 0;
        @(posedge clk); #1;
        i_dc_read = 1'b1; i_dc_addr = 32'h300; i_l2_waitrequest = 1'b1;
        @(posedge clk); #1;
        i_dc_read = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (o_l2_read === 1'b1 && o_l2_addr === 32'h300 &&
                o_ic_waitrequest === 1'b1 && o_dc_waitrequest === 1'b1) stable++;
            @(posedge clk); #1;
            if (k == 4) i_l2_waitrequest = 1'b0;
        end
        i_l2_waitrequest = 1'b0;
        checks++;
        if (stable != 6) begin
            failures++;
            $display("FAIL l2_wait_stable got %0d cycles exp 6", stable);
        end
        @(negedge clk);
        checks++;
        if (o_l2_read !== 1'b0 || o_dc_waitrequest !== 1'b1) begin
            failures++;
            $display("FAIL l2_wait_resp got rd=%b dc_wr=%b exp 0 1", o_l2_read, o_dc_waitrequest);
        end
        @(posedge clk); #1;
        i_l2_readdata_valid = 1'b1; i_l2_readdata = 128'h1234;
        @(negedge clk);
        checks++;
        if ({o_dc_readdata_valid, o_ic_readdata_valid} !== 2'b10 || o_dc_readdata !== 128'h1234)
        begin
            failures++;
            $display("FAIL l2_wait_route got dc/ic=%b data=%h exp 10 1234",
                     {o_dc_readdata_valid, o_ic_readdata_valid}, o_dc_readdata);
        end
        @(posedge clk); #1;
        i_l2_readdata_valid = 1'b0;
    endtask

    task automatic test_spurious();
        logic seen = 1'b0;
        @(posedge clk); #1;
        i_l2_readdata_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (o_ic_readdata_valid !== 1'b0 || o_dc_readdata_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        i_l2_readdata_valid = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL spurious_valid got strobe=%b exp 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        i_dc_read = 1'b1; i_dc_addr = 32'h400;
        @(posedge clk); #1;
        i_dc_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_l2_read, o_dc_readdata_valid, o_ic_waitrequest, o_dc_waitrequest} !== 4'b0011) begin
            failures++;
            $display("FAIL mid_reset got rd/dcv/icw/dcw=%b exp 0011",
                     {o_l2_read, o_dc_readdata_valid, o_ic_waitrequest, o_dc_waitrequest});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        i_l2_readdata_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_dc_readdata_valid, o_ic_readdata_valid, o_l2_read} !== 3'b000) begin
            failures++;
            $display("FAIL late_resp got dcv/icv/rd=%b exp 000",
                     {o_dc_readdata_valid, o_ic_readdata_valid, o_l2_read});
        end
        @(posedge clk); #1;
        i_l2_readdata_valid = 1'b0;
        i_ic_read = 1'b1; i_ic_addr = 32'h200;
        @(negedge clk);
        checks++;
        if (o_ic_waitrequest !== 1'b0) begin
            failures++;
            $display("FAIL post_rst_accept got ic waitreq=%b exp 0", o_ic_waitrequest);
        end
        @(posedge clk); #1;
        i_ic_read = 1'b0;
        @(negedge clk);
        checks++;
        if (o_l2_read !== 1'b1 || o_l2_addr !== 32'h200) begin
            failures++;
            $display("FAIL post_rst_issue got rd=%b addr=%h exp 1 200", o_l2_read, o_l2_addr);
        end
        @(posedge clk); #1;
        i_l2_readdata_valid = 1'b1; i_l2_readdata = 128'hBEEF;
        @(negedge clk);
        checks++;
        if ({o_ic_readdata_valid, o_dc_readdata_valid} !== 2'b10 || o_ic_readdata !== 128'hBEEF)
        begin
            failures++;
            $display("FAIL post_rst_resp got ic/dc=%b data=%h exp 10 beef",
                     {o_ic_readdata_valid, o_dc_readdata_valid}, o_ic_readdata);
        end
        @(posedge clk); #1;
        i_l2_readdata_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i_ic_addr = '0; i_ic_read = 1'b0;
        i_dc_addr = '0; i_dc_writedata = '0; i_dc_read = 1'b0; i_dc_write = 1'b0;
        i_l2_readdata = '0; i_l2_readdata_valid = 1'b0; i_l2_waitrequest = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_contention();
        test_dc_write();
        test_rw_conflict();
        test_l2_wait();
        test_spurious();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
